// File: rtl/guineveer_mailbox_ctrl.sv
// rtl/guineveer_mailbox_ctrl.sv - AXI4 write sink for the sim/firmware mailbox with char FIFO and pass/fail flags.
// Optional feature macro: MAILBOX_DROP_ON_FULL_EN (drop printable bytes on full FIFO instead of stalling W).
module guineveer_mailbox_ctrl #(
  parameter int unsigned          AXI_ADDR_W   = 32,
  parameter int unsigned          AXI_DATA_W   = 64,
  parameter int unsigned          AXI_ID_W     = 4,
  parameter logic [AXI_ADDR_W-1:0] MAILBOX_ADDR = 32'h80F8_0000,
  parameter int unsigned          FIFO_DEPTH   = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    awvalid_i,
  output logic                    awready_o,
  input  logic [AXI_ADDR_W-1:0]   awaddr_i,
  input  logic [AXI_ID_W-1:0]     awid_i,
  input  logic                    wvalid_i,
  output logic                    wready_o,
  input  logic [AXI_DATA_W-1:0]   wdata_i,
  input  logic [AXI_DATA_W/8-1:0] wstrb_i,
  input  logic                    wlast_i,
  output logic                    bvalid_o,
  input  logic                    bready_i,
  output logic [AXI_ID_W-1:0]     bid_o,
  output logic [1:0]              bresp_o,
  output logic                    char_valid_o,
  output logic [7:0]              char_data_o,
  input  logic                    char_ready_i,
  output logic                    pass_o,
  output logic                    fail_o,
  output logic [15:0]             drop_cnt_o
);
  localparam int unsigned STRB_W = AXI_DATA_W / 8;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, DATA, RESP} state_e;

  state_e              state_q, state_d;
  logic                hit_q, hit_d;
  logic [AXI_ID_W-1:0] id_q, id_d;
  logic                pass_q, pass_d, fail_q, fail_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [7:0]          mem_q [FIFO_DEPTH];

  logic       full, w_hs, decode, push_req, push, pop;
  logic [7:0] b;
  logic       unused_bits;

  assign unused_bits = ^{wdata_i[AXI_DATA_W-1:8], wstrb_i[STRB_W-1:1]};

  assign full     = (count_q == CNT_W'(FIFO_DEPTH));
  assign b        = wdata_i[7:0];
  assign w_hs     = wvalid_i && wready_o;
  assign decode   = w_hs && hit_q && wstrb_i[0];
  assign push_req = decode && (b >= 8'h06) && (b <= 8'h7E);
  assign pop      = char_valid_o && char_ready_i;

`ifdef MAILBOX_DROP_ON_FULL_EN
  logic        drop;
  logic [15:0] drop_cnt_q, drop_cnt_d;
  assign push = push_req && !full;
  assign drop = push_req && full;
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) drop_cnt_q <= '0;
    else         drop_cnt_q <= drop_cnt_d;
  end
  assign drop_cnt_o = drop_cnt_q;
`else
  // Stall mode: wready_o already holds off beats while full, so every request fits.
  assign push       = push_req;
  assign drop_cnt_o = 16'd0;
`endif

  always_comb begin
    state_d   = state_q;
    hit_d     = hit_q;
    id_d      = id_q;
    awready_o = 1'b0;
    wready_o  = 1'b0;
    bvalid_o  = 1'b0;
    case (state_q)
      IDLE: begin
        // Gated by rst_ni so awready stays low while reset is held.
        awready_o = rst_ni;
        if (awvalid_i && rst_ni) begin
          hit_d   = (awaddr_i == MAILBOX_ADDR);
          id_d    = awid_i;
          state_d = DATA;
        end
      end
      DATA: begin
`ifdef MAILBOX_DROP_ON_FULL_EN
        wready_o = 1'b1;
`else
        wready_o = !(hit_q && full);
`endif
        if (wvalid_i && wready_o && wlast_i) state_d = RESP;
      end
      RESP: begin
        bvalid_o = 1'b1;
        if (bready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bid_o   = bvalid_o ? id_q : '0;
  assign bresp_o = (bvalid_o && !hit_q) ? 2'b10 : 2'b00;

  always_comb begin
    pass_d   = pass_q || (decode && b == 8'hFF);
    fail_d   = fail_q || (decode && b == 8'h01);
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      hit_q    <= 1'b0;
      id_q     <= '0;
      pass_q   <= 1'b0;
      fail_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      hit_q    <= hit_d;
      id_q     <= id_d;
      pass_q   <= pass_d;
      fail_q   <= fail_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= b;
  end

  assign char_valid_o = (count_q != '0);
  assign char_data_o  = char_valid_o ? mem_q[rd_ptr_q] : 8'h00;
  assign pass_o       = pass_q;
  assign fail_o       = fail_q;
endmodule

// File: tb/tb_guineveer_mailbox_ctrl.sv
// tb/tb_guineveer_mailbox_ctrl.sv - directed self-checking bench for guineveer_mailbox_ctrl.
module tb_guineveer_mailbox_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        awvalid, awready;
  logic [31:0] awaddr;
  logic [3:0]  awid;
  logic        wvalid, wready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wlast;
  logic        bvalid, bready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        char_valid, char_ready;
  logic [7:0]  char_data;
  logic        pass, fail;
  logic [15:0] drop_cnt;

  int errors = 0;
  int checks = 0;

  logic       snap_valid, snap_pass, snap_fail;
  logic [7:0] snap_data;

  always #5 clk = ~clk;

  guineveer_mailbox_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n),
    .awvalid_i(awvalid), .awready_o(awready), .awaddr_i(awaddr), .awid_i(awid),
    .wvalid_i(wvalid), .wready_o(wready), .wdata_i(wdata), .wstrb_i(wstrb), .wlast_i(wlast),
    .bvalid_o(bvalid), .bready_i(bready), .bid_o(bid), .bresp_o(bresp),
    .char_valid_o(char_valid), .char_data_o(char_data), .char_ready_i(char_ready),
    .pass_o(pass), .fail_o(fail), .drop_cnt_o(drop_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // All tasks enter and leave at a negedge.
  task automatic do_aw(input logic [31:0] addr, input logic [3:0] id);
    int n = 0;
    awvalid = 1'b1; awaddr = addr; awid = id;
    while (!awready && n < 20) begin @(negedge clk); n++; end
    check("aw_ready", {31'd0, awready}, 32'd1);
    @(negedge clk);
    awvalid = 1'b0;
  endtask

  task automatic do_w(input logic [7:0] data, input logic [7:0] strb);
    int n = 0;
    wvalid = 1'b1; wdata = {56'hA5A5_A5A5_A5A5_A5, data}; wstrb = strb; wlast = 1'b1;
    while (!wready && n < 20) begin @(negedge clk); n++; end
    check("w_ready", {31'd0, wready}, 32'd1);
    @(negedge clk);
    wvalid = 1'b0; wlast = 1'b0;
    snap_valid = char_valid; snap_data = char_data; snap_pass = pass; snap_fail = fail;
  endtask

  task automatic do_b(input logic [1:0] exp_resp, input logic [3:0] exp_id);
    check("b_valid", {31'd0, bvalid}, 32'd1);
    check("b_id", {28'd0, bid}, {28'd0, exp_id});
    check("b_resp", {30'd0, bresp}, {30'd0, exp_resp});
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    check("aw_ready_after_b", {31'd0, awready}, 32'd1);
  endtask

  task automatic write_txn(input logic [31:0] addr, input logic [3:0] id,
                           input logic [7:0] data, input logic [7:0] strb,
                           input logic [1:0] exp_resp);
    do_aw(addr, id);
    do_w(data, strb);
    do_b(exp_resp, id);
  endtask

  initial begin
    rst_n = 1'b0; awvalid = 0; awaddr = 0; awid = 0; wvalid = 0; wdata = 0;
    wstrb = 0; wlast = 0; bready = 0; char_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_awready", {31'd0, awready}, 32'd0);
    check("rst_wready", {31'd0, wready}, 32'd0);
    check("rst_bvalid", {31'd0, bvalid}, 32'd0);
    check("rst_char_valid", {31'd0, char_valid}, 32'd0);
    check("rst_flags", {30'd0, pass, fail}, 32'd0);
    check("rst_drop_cnt", {16'd0, drop_cnt}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_awready", {31'd0, awready}, 32'd1);

    // 'H' then 'i' with consumer ready.
    write_txn(32'h80F8_0000, 4'h3, 8'h48, 8'h01, 2'b00);
    check("h_valid", {31'd0, snap_valid}, 32'd1);
    check("h_data", {24'd0, snap_data}, 32'h48);
    write_txn(32'h80F8_0000, 4'hC, 8'h69, 8'h01, 2'b00);
    check("i_valid", {31'd0, snap_valid}, 32'd1);
    check("i_data", {24'd0, snap_data}, 32'h69);
    check("hi_drained", {31'd0, char_valid}, 32'd0);

    // Miss address: SLVERR, no side effects.
    write_txn(32'h80F8_0008, 4'h5, 8'h41, 8'h01, 2'b10);
    check("miss_fifo", {31'd0, snap_valid}, 32'd0);
    check("miss_flags", {30'd0, snap_pass, snap_fail}, 32'd0);

    // Ignored values and masked strobe.
    write_txn(32'h80F8_0000, 4'h1, 8'h05, 8'h01, 2'b00);
    check("ign05_fifo", {31'd0, snap_valid}, 32'd0);
    write_txn(32'h80F8_0000, 4'h2, 8'h7F, 8'h01, 2'b00);
    check("ign7f_fifo", {31'd0, snap_valid}, 32'd0);
    write_txn(32'h80F8_0000, 4'h4, 8'h41, 8'h00, 2'b00);
    check("strb0_fifo", {31'd0, snap_valid}, 32'd0);
    check("ign_flags", {30'd0, pass, fail}, 32'd0);

    // Pass then fail, both sticky.
    write_txn(32'h80F8_0000, 4'h7, 8'hFF, 8'h01, 2'b00);
    check("pass_set", {30'd0, snap_pass, snap_fail}, 32'b10);
    write_txn(32'h80F8_0000, 4'h8, 8'h01, 8'h01, 2'b00);
    check("fail_set", {30'd0, snap_pass, snap_fail}, 32'b11);

    // Fill the FIFO with the consumer stalled.
    char_ready = 1'b0;
    for (int i = 0; i < 8; i++) write_txn(32'h80F8_0000, 4'h9, 8'h50 + 8'(i), 8'h01, 2'b00);
    check("full_head", {24'd0, char_data}, 32'h50);
`ifdef MAILBOX_DROP_ON_FULL_EN
    write_txn(32'h80F8_0000, 4'hA, 8'h58, 8'h01, 2'b00);
    check("drop_cnt_one", {16'd0, drop_cnt}, 32'd1);
    char_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("drop_drain_valid", {31'd0, char_valid}, 32'd1);
      check("drop_drain_data", {24'd0, char_data}, {24'd0, 8'h50 + 8'(i)});
      @(negedge clk);
    end
`else
    do_aw(32'h80F8_0000, 4'hA);
    wvalid = 1'b1; wdata = 64'h58; wstrb = 8'h01; wlast = 1'b1;
    check("stall_wready0", {31'd0, wready}, 32'd0);
    @(negedge clk);
    check("stall_wready1", {31'd0, wready}, 32'd0);
    char_ready = 1'b1;
    check("stall_same_cycle_pop", {31'd0, wready}, 32'd0);
    @(negedge clk);
    char_ready = 1'b0;
    check("stall_open", {31'd0, wready}, 32'd1);
    @(negedge clk);
    wvalid = 1'b0; wlast = 1'b0;
    do_b(2'b00, 4'hA);
    char_ready = 1'b1;
    for (int i = 1; i < 9; i++) begin
      check("stall_drain_valid", {31'd0, char_valid}, 32'd1);
      check("stall_drain_data", {24'd0, char_data}, {24'd0, 8'h50 + 8'(i)});
      @(negedge clk);
    end
`endif
    check("drained_empty", {31'd0, char_valid}, 32'd0);

    // Reset during DATA with a byte queued.
    char_ready = 1'b0;
    write_txn(32'h80F8_0000, 4'h6, 8'h41, 8'h01, 2'b00);
    do_aw(32'h80F8_0000, 4'hB);
    wvalid = 1'b1; wdata = 64'h42; wstrb = 8'h01; wlast = 1'b0;
    check("pre_rst_wready", {31'd0, wready}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_wready", {31'd0, wready}, 32'd0);
    check("midrst_fifo", {31'd0, char_valid}, 32'd0);
    check("midrst_flags", {30'd0, pass, fail}, 32'd0);
    check("midrst_bvalid", {31'd0, bvalid}, 32'd0);
    wvalid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    write_txn(32'h80F8_0000, 4'hD, 8'h41, 8'h01, 2'b00);
    check("fresh_valid", {31'd0, snap_valid}, 32'd1);
    check("fresh_data", {24'd0, snap_data}, 32'h41);
    check("fresh_flags", {30'd0, pass, fail}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/guineveer_mailbox_ctrl.md
# guineveer_mailbox_ctrl

AXI4 write-channel sink that owns the simulation/firmware mailbox at `MAILBOX_ADDR` in the Guineveer SoC. It sequences AW/W/B handshakes from the LSU path and decodes the low data byte of each accepted beat. Printable bytes are queued into a character FIFO for a console consumer, 0xFF raises a sticky pass flag, and 0x01 raises a sticky fail flag. This replaces ad-hoc bus snooping with a real bus target that applies backpressure.

## Interface
Parameters:
- `AXI_ADDR_W`, 32, address width
- `AXI_DATA_W`, 64, write data width (multiple of 8)
- `AXI_ID_W`, 4, transaction ID width
- `MAILBOX_ADDR`, 32'h80F8_0000, mailbox word address (exact match on all address bits)
- `FIFO_DEPTH`, 8, character FIFO entries (power of two, ≥2)

Ports:
- `clk_i`  in  1  core clock; single clock domain
- `rst_ni`  in  1  asynchronous active-low reset
- `awvalid_i` in 1, `awready_o` out 1, `awaddr_i` in AXI_ADDR_W, `awid_i` in AXI_ID_W: write address channel
- `wvalid_i` in 1, `wready_o` out 1, `wdata_i` in AXI_DATA_W, `wstrb_i` in AXI_DATA_W/8, `wlast_i` in 1: write data channel
- `bvalid_o` out 1, `bready_i` in 1, `bid_o` out AXI_ID_W, `bresp_o` out 2: write response channel
- `char_valid_o`  out  1  FIFO head valid
- `char_data_o`  out  8  FIFO head byte
- `char_ready_i`  in  1  consumer pops head when high with `char_valid_o`
- `pass_o`  out  1  sticky; 0xFF written to mailbox
- `fail_o`  out  1  sticky; 0x01 written to mailbox
- `drop_cnt_o`  out  16  dropped printable bytes (see Configuration)

## Operation
- FSM states: IDLE, DATA, RESP. Reset state is IDLE.
- IDLE:
  - `awready_o`=1.
  - On the AW handshake, latch `awid_i` and `hit = (awaddr_i == MAILBOX_ADDR)`, then go to DATA.
- DATA:
  - `wready_o` = 1, except when `hit` and the FIFO is full in stall mode.
  - Each W handshake decodes byte `b = wdata_i[7:0]`. A beat is decoded only if `hit` and `wstrb_i[0]` are both set:
    - b == 8'hFF → set `pass_o`
    - b == 8'h01 → set `fail_o`
    - 8'h06 ≤ b ≤ 8'h7E → push `b` into the FIFO
    - any other value → ignored
  - A W handshake with `wlast_i`=1 moves the FSM to RESP.
- RESP:
  - `bvalid_o`=1, `bid_o` = latched ID.
  - `bresp_o` = 2'b00 (OKAY) if `hit`, otherwise 2'b10 (SLVERR).
  - On `bready_i`, go to IDLE.
- `awready_o` is 0 outside IDLE; `wready_o` is 0 outside DATA.
- W beats arriving before their AW are held off by `wready_o`=0.
- FIFO:
  - Circular buffer with read/write pointers that wrap modulo `FIFO_DEPTH`, plus an occupancy count of width clog2(FIFO_DEPTH)+1.
  - Pop when `char_valid_o && char_ready_i`.
  - Push and pop in the same cycle leave the count unchanged.
  - `wready_o` uses the registered full flag; a same-cycle pop does not open `wready_o`.
- `pass_o` and `fail_o` are sticky until reset; both may be set.

## Timing
- Reset values: `awready_o`=0 during reset and 1 in the first cycle after release. All other outputs are 0, and the FIFO is empty.
- AW handshake in cycle N → earliest W acceptance in cycle N+1.
- Last W handshake in cycle M → `bvalid_o` high in cycle M+1.
- B handshake in cycle K → `awready_o` high in cycle K+1. Minimum single-beat transaction is 3 cycles.
- A byte pushed in cycle M appears on `char_valid_o`/`char_data_o` in cycle M+1 (registered FIFO, no bypass).
- `pass_o`/`fail_o` rise in cycle M+1 after the decoding beat.
- Reset asserted mid-transaction aborts immediately: FSM returns to IDLE, the FIFO empties, and the flags and counter clear. No B response is issued for the aborted transaction.

## Configuration
- `MAILBOX_DROP_ON_FULL_EN` defined:
  - `wready_o` is never stalled by FIFO full.
  - A printable byte that arrives when the FIFO is full is discarded.
  - `drop_cnt_o` increments by 1 per discarded byte and saturates at 16'hFFFF.
- Not defined:
  - `wready_o`=0 while `hit` and FIFO full, so no byte is lost.
  - `drop_cnt_o` is tied to 0.

## Test plan
- Write 0x48 ('H') then 0x69 ('i') to 0x80F80000, each as a single beat with strb=0x01 and `char_ready_i`=1 → `char_data_o` shows 0x48 then 0x69. Each B response has `bresp_o`=00 and `bid_o` equal to the AW ID.
- Write 0xFF → `pass_o`=1 one cycle after the W beat. A later 0x01 write → `fail_o`=1 while `pass_o` stays 1.
- Write 0x41 to 0x80F80008 → `bresp_o`=10, FIFO unchanged, flags stay 0.
- With `char_ready_i`=0, write 9 printable bytes with FIFO_DEPTH=8:
  - Stall mode: the 9th `wready_o` stays 0 until one pop; the 9th byte then arrives, and all 9 bytes drain in order across the pointer wrap.
  - DROP mode: the 9th beat is accepted, `drop_cnt_o`=1, and 8 bytes drain.
- Write 0x05, 0x7F, and a 0x41 beat with strb=0x00 → no FIFO push, no flag change, and OKAY responses.
- Assert `rst_ni` low during DATA of a transaction → in the same cycle `wready_o`=0, FIFO empty, flags 0. After release, a fresh 0x41 write completes normally.
